// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the boot loader.
// The loader is the slave; the stream source / memory side is the master.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum frame and writes the payload big-endian
// into instruction memory, holding the CPU in reset until a good frame has landed.
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          error
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [17:0] CAPACITY = 18'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         total_q, total_d;
   logic [7:0]            xor_q, xor_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]            mem_wdata_q, mem_wdata_d;

   logic                  in_ready;
   logic                  accept;
   logic [15:0]           words;
   logic [17:0]           bytes_total;

   assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
   assign accept   = in_ready & bus.in_valid;

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      cnt_d       = cnt_q;
      total_d     = total_q;
      xor_d       = xor_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      words       = {len_hi_q, bus.in_data};
      // 18-bit byte count so a large N cannot alias into a small, accepted size
      bytes_total = {words, 2'b00};

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               cnt_d   = '0;
               xor_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = bus.in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               if (words == 16'd0) begin
                  state_d = S_CHECK;
               end else if (bytes_total > CAPACITY) begin
                  state_d = S_ERROR;
               end else begin
                  total_d = bytes_total[CW-1:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
               mem_wdata_d = bus.in_data;
               xor_d       = xor_q ^ bus.in_data;
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == total_q - CW'(1)) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_hi_q    <= '0;
         cnt_q       <= '0;
         total_q     <= '0;
         xor_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         cnt_q       <= cnt_d;
         total_q     <= total_d;
         xor_q       <= xor_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_hold      = (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: default-size loader for framing/checksum/reset cases, plus a 16-byte
// loader for the capacity-overflow case.
module tb_imem_loader;
   logic clk;
   logic reset;
   logic start0, start1;
   logic cpu_hold0, done0, error0;
   logic cpu_hold1, done1, error1;

   imem_loader_if #(.ADDR_WIDTH(10)) if0 ();
   imem_loader_if #(.ADDR_WIDTH(4))  if1 ();

   imem_loader #(.ADDR_WIDTH(10)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .bus(if0.slave),
      .cpu_hold(cpu_hold0), .done(done0), .error(error0)
   );
   imem_loader #(.ADDR_WIDTH(4)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .bus(if1.slave),
      .cpu_hold(cpu_hold1), .done(done1), .error(error1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int wr_cnt0   = 0;
   int wr_cnt1   = 0;
   int exp_addr  = 0;
   logic [7:0] mem [0:1023];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   // Write monitor: addresses must run 0,1,2,... within a frame, one line per write.
   always @(negedge clk) begin
      if (if0.mem_we === 1'b1) begin
         $display("wr addr=%0d data=%02h", if0.mem_addr, if0.mem_wdata);
         chk("wr_addr", 32'(if0.mem_addr), 32'(exp_addr));
         mem[if0.mem_addr] = if0.mem_wdata;
         exp_addr++;
         wr_cnt0++;
      end
      if (if1.mem_we === 1'b1) wr_cnt1++;
   end

   task automatic pulse_start(input int sel);
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Called and returns on a negedge; the byte is accepted on the intervening posedge.
   task automatic send_byte(input int sel, input logic [7:0] b);
      int t;
      t = 0;
      if (sel == 0) begin if0.in_valid = 1'b1; if0.in_data = b; end
      else          begin if1.in_valid = 1'b1; if1.in_data = b; end
      while (((sel == 0) ? if0.in_ready : if1.in_ready) !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
      $display("tx dut%0d byte=%02h", sel, b);
      @(negedge clk);
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] fr[$], input bit gap);
      foreach (fr[i]) begin
         send_byte(0, fr[i]);
         if (gap && i != fr.size() - 1) begin
            chk("ready_in_gap", 32'(if0.in_ready), 32'd1);
            @(negedge clk);
         end
      end
      @(negedge clk);
   endtask

   task automatic check_good_frame(input string tag);
      chk({tag, "_done"}, 32'(done0), 32'd1);
      chk({tag, "_hold"}, 32'(cpu_hold0), 32'd0);
      chk({tag, "_err"},  32'(error0), 32'd0);
      chk({tag, "_wrcnt"}, 32'(wr_cnt0), 32'd8);
      for (int i = 0; i < 8; i++)
         chk({tag, "_mem"}, 32'(mem[i]), (i == 3) ? 32'h01 : (i == 7) ? 32'h02 : 32'h00);
   endtask

   logic [7:0] f_good[$] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                             8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
   logic [7:0] f_bad[$]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
   logic [7:0] f_z_ok[$] = '{8'h00, 8'h00, 8'h00};
   logic [7:0] f_z_bad[$] = '{8'h00, 8'h00, 8'h01};

   initial begin
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
      if0.in_valid = 1'b0; if0.in_data = '0;
      if1.in_valid = 1'b0; if1.in_data = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_ready", 32'(if0.in_ready), 32'd0);
      chk("rst_we",    32'(if0.mem_we),   32'd0);
      chk("rst_hold",  32'(cpu_hold0),    32'd1);
      chk("rst_done",  32'(done0),        32'd0);
      chk("rst_err",   32'(error0),       32'd0);

      // 1: full-rate good frame
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      send_frame(f_good, 1'b0);
      check_good_frame("t1");

      // 2: same frame with in_valid toggling; memory pre-poisoned to prove rewrite
      for (int i = 0; i < 8; i++) mem[i] = 8'hAA;
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      chk("t2_hold_after_start", 32'(cpu_hold0), 32'd1);
      send_frame(f_good, 1'b1);
      check_good_frame("t2");

      // 3: bad checksum, then recovery with a good frame
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      send_frame(f_bad, 1'b0);
      chk("t3_wrcnt", 32'(wr_cnt0), 32'd4);
      chk("t3_err",   32'(error0),  32'd1);
      chk("t3_done",  32'(done0),   32'd0);
      chk("t3_hold",  32'(cpu_hold0), 32'd1);
      chk("t3_mem0",  32'(mem[0]),  32'hDE);
      chk("t3_mem3",  32'(mem[3]),  32'hEF);
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      send_frame(f_good, 1'b0);
      check_good_frame("t3r");

      // 4: 16-byte memory, N=5 words overflows at LEN_LO
      pulse_start(1);
      send_byte(1, 8'h00);
      send_byte(1, 8'h05);
      chk("t4_err",   32'(error1),      32'd1);
      chk("t4_ready", 32'(if1.in_ready), 32'd0);
      chk("t4_hold",  32'(cpu_hold1),   32'd1);
      @(negedge clk);
      chk("t4_wrcnt", 32'(wr_cnt1), 32'd0);
      chk("t4_done",  32'(done1),   32'd0);

      // 5: empty frame, good and bad checksum
      wr_cnt0 = 0;
      pulse_start(0);
      send_frame(f_z_ok, 1'b0);
      chk("t5_done",  32'(done0),   32'd1);
      chk("t5_wrcnt", 32'(wr_cnt0), 32'd0);
      pulse_start(0);
      send_frame(f_z_bad, 1'b0);
      chk("t5b_err",  32'(error0),  32'd1);
      chk("t5b_done", 32'(done0),   32'd0);

      // 6: reset mid-payload after 3 bytes, then a fresh frame restarts at address 0
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      for (int i = 0; i < 5; i++) send_byte(0, f_good[i]);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_ready", 32'(if0.in_ready),  32'd0);
      chk("t6_we",    32'(if0.mem_we),    32'd0);
      chk("t6_addr",  32'(if0.mem_addr),  32'd0);
      chk("t6_wdata", 32'(if0.mem_wdata), 32'd0);
      chk("t6_hold",  32'(cpu_hold0),     32'd1);
      chk("t6_done",  32'(done0),         32'd0);
      chk("t6_err",   32'(error0),        32'd0);
      chk("t6_partial_wrcnt", 32'(wr_cnt0), 32'd3);
      reset = 1'b0;
      @(negedge clk);
      exp_addr = 0; wr_cnt0 = 0;
      pulse_start(0);
      send_frame(f_good, 1'b0);
      check_good_frame("t6r");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 expected=0");
      $fatal(1, "timeout");
   end
endmodule
